i2s_tdm_tx: RTL and testbench

Master-mode I2S/TDM serial transmitter, the output-side counterpart of the I2S receive path. It accepts PCM words on an AXI-Stream-style input and serialises them MSB-first onto sdata. From the system clock it generates bclk and ws (frame sync). Word width, slot count and format come from the register block. Configuration is latched only at frame boundaries.

---
 rtl/i2s_tdm_tx_pkg.sv | 55 +++++
 rtl/i2s_bclk_gen.sv | 48 ++++
 rtl/i2s_tdm_tx.sv | 150 +++++++++++++++
 tb/tb_i2s_tdm_tx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_tdm_tx_pkg.sv
// Shared I2S/TDM transmitter constants, frame config payload and frame-geometry helpers.
package i2s_tdm_tx_pkg;

  localparam int unsigned POS_W    = 9;
  localparam int unsigned SHIFT_W  = 32;
  localparam int unsigned WORD_W16 = 16;
  localparam int unsigned WORD_W32 = 32;

  localparam int unsigned SLOTS_TDM0 = 2;
  localparam int unsigned SLOTS_TDM1 = 4;
  localparam int unsigned SLOTS_TDM2 = 8;
  localparam int unsigned SLOTS_TDM3 = 16;

  localparam logic FMT_I2S = 1'b0;
  localparam logic FMT_TDM = 1'b1;

  typedef struct packed {
    logic       fmt;
    logic       word_width;
    logic [1:0] tdm_num;
  } frame_cfg_t;

  localparam frame_cfg_t CFG_RESET = '{fmt: FMT_I2S, word_width: 1'b0, tdm_num: 2'd0};

  function automatic logic [5:0] slot_width(input logic word_width);
    return word_width ? 6'(WORD_W32) : 6'(WORD_W16);
  endfunction

  // I2S always carries exactly two slots regardless of tdm_num.
  function automatic logic [4:0] slot_count(input frame_cfg_t cfg);
    logic [4:0] n;
    n = 5'(SLOTS_TDM0);
    if (cfg.fmt == FMT_TDM) begin
      case (cfg.tdm_num)
        2'd0: n = 5'(SLOTS_TDM0);
        2'd1: n = 5'(SLOTS_TDM1);
        2'd2: n = 5'(SLOTS_TDM2);
        2'd3: n = 5'(SLOTS_TDM3);
        default: n = 5'(SLOTS_TDM0);
      endcase
    end
    return n;
  endfunction

  function automatic logic [POS_W-1:0] frame_last(input frame_cfg_t cfg);
    logic [POS_W:0] bits;
    bits = (POS_W+1)'(slot_count(cfg)) * (POS_W+1)'(slot_width(cfg.word_width));
    return POS_W'(bits - (POS_W+1)'(1));
  endfunction

  function automatic logic slot_start(input logic [POS_W-1:0] pos, input logic word_width);
    return word_width ? (pos[4:0] == 5'd0) : (pos[3:0] == 4'd0);
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: toggles bclk every div+1 clk cycles and flags the rise/fall toggles.
module i2s_bclk_gen #(
  parameter int unsigned DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 bclk,
  output logic                 rise_evt,
  output logic                 fall_evt
);

  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic                 bclk_q, bclk_d;

  // Events are asserted in the cycle whose closing edge performs the toggle.
  always_comb begin
    div_cnt_d = div_cnt_q;
    bclk_d    = bclk_q;
    rise_evt  = 1'b0;
    fall_evt  = 1'b0;
    if (!run) begin
      div_cnt_d = '0;
      bclk_d    = 1'b0;
    end else if (div_cnt_q == div) begin
      div_cnt_d = '0;
      bclk_d    = !bclk_q;
      rise_evt  = !bclk_q;
      fall_evt  = bclk_q;
    end else begin
      div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  assign bclk = bclk_q;

endmodule

// File: rtl/i2s_tdm_tx.sv
// Master-mode I2S/TDM transmitter: frame position, ws/sdata generation and per-slot load handshake.
module i2s_tdm_tx
  import i2s_tdm_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DIV_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fmt,
  input  logic                  word_width,
  input  logic [1:0]            tdm_num,
  input  logic [DIV_WIDTH-1:0]  bclk_div,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic                  bclk,
  output logic                  ws,
  output logic                  sdata,
  output logic                  frame_start,
  output logic                  underrun
);

  frame_cfg_t           cfg_q, cfg_d, cfg_in;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 run_q, run_d;
  logic                 armed_q, armed_d;
  logic                 started_q, started_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic [SHIFT_W-1:0]   tdata_w;
  logic                 ws_q, ws_d;
  logic                 sdata_q, sdata_d;
  logic                 frame_start_q, frame_start_d;
  logic                 underrun_q, underrun_d;
  logic                 load_c;
  logic                 wrap_c;
  logic                 rise_evt, fall_evt;

  assign cfg_in = '{fmt: fmt, word_width: word_width, tdm_num: tdm_num};

  i2s_bclk_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_bclk_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (enable && run_q),
    .div     (div_q),
    .bclk    (bclk),
    .rise_evt(rise_evt),
    .fall_evt(fall_evt)
  );

  // All serial state moves on fall events; config is only swapped on the wrap to p=0.
  always_comb begin
    run_d         = run_q;
    armed_d       = armed_q;
    started_d     = started_q;
    cfg_d         = cfg_q;
    div_d         = div_q;
    pos_d         = pos_q;
    shift_d       = shift_q;
    ws_d          = ws_q;
    sdata_d       = sdata_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    load_c        = 1'b0;
    wrap_c        = started_q && (pos_q == frame_last(cfg_q));
    tdata_w       = SHIFT_W'(s_tdata);

    if (!enable) begin
      run_d     = 1'b0;
      armed_d   = 1'b0;
      started_d = 1'b0;
      cfg_d     = CFG_RESET;
      div_d     = '0;
      pos_d     = '0;
      shift_d   = '0;
      ws_d      = 1'b0;
      sdata_d   = 1'b0;
    end else if (!run_q) begin
      run_d = 1'b1;
      cfg_d = cfg_in;
      div_d = bclk_div;
    end else begin
      if (rise_evt) armed_d = 1'b1;
      if (fall_evt && armed_q) begin
        started_d = 1'b1;
        if (wrap_c) begin
          cfg_d = cfg_in;
          div_d = bclk_div;
        end
        pos_d = (!started_q || wrap_c) ? '0 : pos_q + POS_W'(1);
        if (cfg_d.fmt == FMT_TDM) ws_d = (pos_d == '0);
        else ws_d = (pos_d >= POS_W'(slot_width(cfg_d.word_width)));
        sdata_d       = shift_q[SHIFT_W-1];
        frame_start_d = (pos_d == '0);
        // Slot boundary: the previous slot's LSB leaves now, the new word is latched behind it.
        if (slot_start(pos_d, cfg_d.word_width)) begin
          load_c = 1'b1;
          if (s_tvalid) begin
            shift_d = cfg_d.word_width ? tdata_w
                                       : {tdata_w[WORD_W16-1:0], (SHIFT_W-WORD_W16)'(0)};
          end else begin
            shift_d    = '0;
            underrun_d = 1'b1;
          end
        end else begin
          shift_d = shift_q << 1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q         <= 1'b0;
      armed_q       <= 1'b0;
      started_q     <= 1'b0;
      cfg_q         <= CFG_RESET;
      div_q         <= '0;
      pos_q         <= '0;
      shift_q       <= '0;
      ws_q          <= 1'b0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      run_q         <= run_d;
      armed_q       <= armed_d;
      started_q     <= started_d;
      cfg_q         <= cfg_d;
      div_q         <= div_d;
      pos_q         <= pos_d;
      shift_q       <= shift_d;
      ws_q          <= ws_d;
      sdata_q       <= sdata_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign s_tready    = load_c;
  assign ws          = ws_q;
  assign sdata       = sdata_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Directed self-checking bench for i2s_tdm_tx: samples every bclk fall and checks against hand-derived frames.
module tb_i2s_tdm_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        fmt;
  logic        word_width;
  logic [1:0]  tdm_num;
  logic [7:0]  bclk_div;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        bclk;
  logic        ws;
  logic        sdata;
  logic        frame_start;
  logic        underrun;

  always #5 clk = ~clk;

  i2s_tdm_tx #(.DATA_WIDTH(32), .DIV_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fmt(fmt), .word_width(word_width),
    .tdm_num(tdm_num), .bclk_div(bclk_div), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready), .bclk(bclk), .ws(ws), .sdata(sdata),
    .frame_start(frame_start), .underrun(underrun)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc, load_cnt, ur_cnt, fs_cnt, nwords;
  int drop_load = -1;
  logic [31:0] words [16];
  logic sd [0:1023];
  logic wsv [0:1023];
  logic fsv [0:1023];
  logic urv [0:1023];
  int   fcyc [0:1023];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clk; presents the next word whenever the DUT opens a load slot.
  task automatic clk_step();
    @(negedge clk);
    cyc++;
    if (underrun) ur_cnt++;
    if (frame_start) fs_cnt++;
    if (s_tready) begin
      s_tvalid = (load_cnt != drop_load);
      s_tdata  = words[load_cnt % nwords];
      load_cnt++;
    end
  endtask

  task automatic wait_fall(output bit ok);
    bit prev;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      prev = bclk;
      clk_step();
      if (prev && !bclk) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_falls(input int first, input int n);
    bit ok;
    for (int i = first; i < first + n; i++) begin
      wait_fall(ok);
      if (!ok) begin
        n_cmp++;
        n_err++;
        $error("FAIL fall_timeout: no bclk fall at index %0d", i);
        return;
      end
      sd[i] = sdata; wsv[i] = ws; fsv[i] = frame_start; urv[i] = underrun; fcyc[i] = cyc;
    end
  endtask

  task automatic start(input logic f, input logic ww, input logic [1:0] tn, input logic [7:0] dv);
    enable = 1'b0;
    clk_step();
    fmt = f; word_width = ww; tdm_num = tn; bclk_div = dv;
    load_cnt = 0; ur_cnt = 0; fs_cnt = 0; cyc = 0;
    enable = 1'b1;
  endtask

  function automatic logic [31:0] get_word(input int p0, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r = {r[30:0], sd[p0+i]};
    return r;
  endfunction

  function automatic logic [31:0] pack_ws(input int p0);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = wsv[p0+i];
    return r;
  endfunction

  function automatic logic [31:0] outs_vec();
    return 32'({bclk, ws, sdata, frame_start, underrun, s_tready});
  endfunction

  initial begin
    int c;
    logic [31:0] wexp;
    rst_n = 1'b0; enable = 1'b0; fmt = 1'b0; word_width = 1'b0; tdm_num = 2'd0;
    bclk_div = 8'd0; s_tdata = '0; s_tvalid = 1'b0; nwords = 1; words[0] = '0;
    load_cnt = 0; ur_cnt = 0; fs_cnt = 0; cyc = 0;
    repeat (3) clk_step();
    chk("reset_outs", outs_vec(), 32'h0);
    rst_n = 1'b1;

    // 1: I2S 16-bit div=1, upper halves must be ignored
    words[0] = 32'hFFFF_A5A5; words[1] = 32'h1234_5A5A; nwords = 2;
    start(1'b0, 1'b0, 2'd0, 8'd1);
    run_falls(0, 64);
    chk("t1_first_fall_lat", 32'(fcyc[0]), 32'd5);
    chk("t1_bclk_period", 32'(fcyc[1] - fcyc[0]), 32'd4);
    chk("t1_first_bits", get_word(0, 9), 32'h0A5);
    chk("t1_left_word", get_word(1, 16), 32'hA5A5);
    chk("t1_right_word", get_word(17, 16), 32'h5A5A);
    chk("t1_right_bit18", 32'(sd[18]), 32'd1);
    chk("t1_ws_frame0", pack_ws(0), 32'hFFFF_0000);
    chk("t1_ws_frame1", pack_ws(32), 32'hFFFF_0000);
    chk("t1_prev_lsb_p0", 32'(sd[32]), 32'd0);
    chk("t1_left_word_f1", get_word(33, 16), 32'hA5A5);
    chk("t1_fs_p0", 32'({fsv[0], fsv[32], fsv[16]}), 32'b110);
    chk("t1_fs_count", 32'(fs_cnt), 32'd2);
    chk("t1_loads", 32'(load_cnt), 32'd4);
    chk("t1_no_underrun", 32'(ur_cnt), 32'd0);
    enable = 1'b0;
    clk_step();
    chk("t1_disable_outs", outs_vec(), 32'h0);

    // 2: TDM 8 slots 32-bit div=0, words 0..7
    for (int k = 0; k < 8; k++) words[k] = 32'(k);
    nwords = 8;
    start(1'b1, 1'b1, 2'd2, 8'd0);
    run_falls(0, 257);
    chk("t2_first_fall_lat", 32'(fcyc[0]), 32'd3);
    chk("t2_bclk_period", 32'(fcyc[1] - fcyc[0]), 32'd2);
    c = 0;
    for (int p = 0; p < 256; p++) c += int'(wsv[p]);
    chk("t2_fsync_count", 32'(c), 32'd1);
    chk("t2_fsync_pos", 32'({wsv[0], wsv[1], wsv[256]}), 32'b101);
    chk("t2_loads", 32'(load_cnt), 32'd9);
    c = 0;
    for (int p = 1; p <= 256; p++) begin
      wexp = 32'((p - 1) / 32);
      if (sd[p] !== wexp[31 - ((p - 1) % 32)]) c++;
    end
    chk("t2_data_bit_errs", 32'(c), 32'd0);
    chk("t2_bits", 32'({sd[0], sd[64], sd[95], sd[256], sd[63]}), 32'b01110);

    // 3: underrun on slot 1 (TDM 4 slots, 16-bit)
    words[0] = 32'h1234; words[1] = 32'hABCD; words[2] = 32'h5678; words[3] = 32'h9ABC;
    nwords = 4; drop_load = 1;
    start(1'b1, 1'b0, 2'd1, 8'd0);
    run_falls(0, 65);
    drop_load = -1;
    chk("t3_restart_p0", 32'({sd[0], fsv[0], wsv[0], wsv[16]}), 32'b0110);
    chk("t3_slot0", get_word(1, 16), 32'h1234);
    chk("t3_slot1_zero", get_word(17, 16), 32'h0);
    chk("t3_slot2", get_word(33, 16), 32'h5678);
    chk("t3_slot3", get_word(49, 16), 32'h9ABC);
    chk("t3_ur_at_slot1", 32'({urv[0], urv[16], urv[32]}), 32'b010);
    chk("t3_ur_count", 32'(ur_cnt), 32'd1);

    // 4: word_width 0->1 mid-frame takes effect on the next frame
    words[0] = 32'hDEAD_BEEF; words[1] = 32'h1234_5678; nwords = 2;
    start(1'b0, 1'b0, 2'd0, 8'd0);
    run_falls(0, 10);
    word_width = 1'b1;
    run_falls(10, 87);
    chk("t4_ws_frame0", pack_ws(0), 32'hFFFF_0000);
    chk("t4_fs_positions", 32'({fsv[32], fsv[64], fsv[96]}), 32'b101);
    chk("t4_fs_count", 32'(fs_cnt), 32'd3);
    chk("t4_ws_long_frame", 32'({wsv[48], wsv[63], wsv[64], wsv[95]}), 32'b0011);
    chk("t4_old_slot1", get_word(17, 16), 32'h5678);
    chk("t4_new_slot0", get_word(33, 32), 32'hDEAD_BEEF);

    // 5: reset at p=100 and enable drop mid-frame
    words[0] = 32'h0000_FFFF; nwords = 1;
    start(1'b1, 1'b0, 2'd2, 8'd0);
    run_falls(0, 101);
    chk("t5_pre_reset", 32'({sd[100], wsv[100]}), 32'b10);
    rst_n = 1'b0;
    clk_step();
    chk("t5_reset_outs", outs_vec(), 32'h0);
    rst_n = 1'b1;
    cyc = 0; load_cnt = 0; fs_cnt = 0;
    run_falls(0, 2);
    chk("t5_restart_lat", 32'(fcyc[0]), 32'd3);
    chk("t5_restart_p0", 32'({sd[0], fsv[0], wsv[0], sd[1]}), 32'b0111);
    run_falls(2, 20);
    chk("t5_mid_sdata", 32'(sd[21]), 32'd1);
    enable = 1'b0;
    clk_step();
    chk("t5_disable_outs", outs_vec(), 32'h0);

    // 6: I2S ignores tdm_num, div=2
    words[0] = 32'h1111; words[1] = 32'h2222; nwords = 2;
    start(1'b0, 1'b0, 2'd3, 8'd2);
    run_falls(0, 33);
    chk("t6_first_fall_lat", 32'(fcyc[0]), 32'd7);
    chk("t6_bclk_period", 32'(fcyc[1] - fcyc[0]), 32'd6);
    chk("t6_loads", 32'(load_cnt), 32'd3);
    chk("t6_fs_wrap", 32'({fsv[0], fsv[32]}), 32'b11);
    chk("t6_ws_frame", pack_ws(0), 32'hFFFF_0000);
    chk("t6_slot1", get_word(17, 16), 32'h2222);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
